// File: rtl/avalon_s_ram.sv
// Avalon-MM slave single-port RAM with a programmable number of wait states.
// One transfer at a time, fixed latency, no readdatavalid.
module avalon_s_ram #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WS    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            avn_read,
  input  logic            avn_write,
  input  logic [AW-1:0]   avn_address,
  input  logic [DW/8-1:0] avn_byte_enable,
  input  logic [DW-1:0]   avn_writedata,
  output logic [DW-1:0]   avn_readdata,
  output logic            avn_waitrequest
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned OW = (BW > 1) ? $clog2(BW) : 0;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          wait_q, wait_d;
  logic          we_c;
  logic          req_c;
  logic          rd_only_c;
  logic [IW-1:0] addr_idx_c;
  logic          unused_addr_c;

  logic [DW-1:0] mem [DEPTH];

  // Request decode; a simultaneous read and write is a write.
  assign req_c         = avn_read | avn_write;
  assign rd_only_c     = avn_read & ~avn_write;
  assign addr_idx_c    = avn_address[OW +: IW];
  assign unused_addr_c = ^avn_address;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped request in WAIT abandons the transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_c) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!req_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath control for the current state.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    hold_d = hold_q;
    we_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          idx_d = addr_idx_c;
          cnt_d = CW'(WS);
        end
      end
      ST_WAIT: begin
        if (req_c) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (rd_only_c) begin
            hold_d = mem[idx_q];
          end
        end
      end
      ST_ACK:  we_c = avn_write;
      default: ;
    endcase
    wait_d = (state_d != ST_ACK);
  end

  // Datapath registers; waitrequest is registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      hold_q <= '0;
      wait_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
      wait_q <= wait_d;
    end
  end

  // RAM byte-lane write in the ACK cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_c && !rst) begin
      for (int k = 0; k < int'(BW); k++) begin
        if (avn_byte_enable[k]) begin
          mem[addr_idx_c][8*k +: 8] <= avn_writedata[8*k +: 8];
        end
      end
    end
  end

  assign avn_readdata    = hold_q;
  assign avn_waitrequest = wait_q;

endmodule
